// File: rtl/cc_mem_read_responder.sv
// AXI read-channel memory responder: one AR at a time, INCR burst of 64-bit beats after a fixed latency.
// Optional CC_MEM_RANGE_CHK_EN: out-of-range AR addresses return SLVERR beats with zero data.
module cc_mem_read_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_arvalid_i,
    output logic              mem_arready_o,
    input  logic [31:0]       mem_araddr_i,
    input  logic [3:0]        mem_arlen_i,
    output logic [63:0]       mem_rdata_o,
    output logic [1:0]        mem_rresp_o,
    output logic              mem_rlast_o,
    output logic              mem_rvalid_o,
    input  logic              mem_rready_i,
    input  logic              init_wren_i,
    input  logic [ADDR_W-1:0] init_waddr_i,
    input  logic [63:0]       init_wdata_i
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                ar_hs_c;
    logic                r_hs_c;
    logic                req_err_c;
    logic [ADDR_W-1:0]   rd_idx_c;
    logic [DATA_W-1:0]   rd_word_c;
    logic                unused_araddr_c;

    assign ar_hs_c = mem_arvalid_i && arready_q;
    assign r_hs_c  = rvalid_q && mem_rready_i;

`ifdef CC_MEM_RANGE_CHK_EN
    assign req_err_c = (mem_araddr_i >> (ADDR_W + 3)) != 32'd0;
`else
    assign req_err_c = 1'b0;
`endif

    // Byte-offset bits (and, without range checking, the upper bits) are intentionally ignored.
    assign unused_araddr_c = ^mem_araddr_i;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ar_hs_c) begin
                    base_d  = mem_araddr_i[ADDR_W+2:3];
                    len_d   = mem_arlen_i;
                    beat_d  = '0;
                    cnt_d   = '0;
                    err_d   = req_err_c;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = S_BURST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BURST: begin
                if (r_hs_c) begin
                    if (beat_q == len_q) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        arready_d = (state_d == S_IDLE);
        rvalid_d  = (state_d == S_BURST);

        // Read the word for the beat presented next cycle; bypass a same-cycle preload of that word.
        rd_idx_c  = base_d + ADDR_W'(beat_d);
        rd_word_c = (init_wren_i && (init_waddr_i == rd_idx_c)) ? init_wdata_i : mem_q[rd_idx_c];

        if (state_d == S_BURST) begin
            rdata_d = err_d ? '0 : rd_word_c;
            rlast_d = (beat_d == len_d);
            rresp_d = err_d ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Preload port; array contents survive reset.
    always_ff @(posedge clk) begin
        if (init_wren_i) begin
            mem_q[init_waddr_i] <= init_wdata_i;
        end
    end

    assign mem_arready_o = arready_q;
    assign mem_rvalid_o  = rvalid_q;
    assign mem_rlast_o   = rlast_q;
    assign mem_rresp_o   = rresp_q;
    assign mem_rdata_o   = rdata_q;

endmodule
